// File: rtl/fifo_level_if.sv
// fifo_level_if: handshake, data and status bundle of the show-ahead FIFO.
// overflow/underflow exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_level_if #(
    parameter int WIDTH     = 512,
    parameter int LOG_DEPTH = 9
);
    logic                 wrreq;
    logic [WIDTH-1:0]     data;
    logic                 rdreq;
    logic [WIDTH-1:0]     q;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [LOG_DEPTH:0]   usedw;
`ifdef FIFO_ERR_FLAGS_EN
    logic                 overflow;
    logic                 underflow;
    modport master (output wrreq, data, rdreq,
                    input  q, full, empty, almost_full, almost_empty, usedw, overflow, underflow);
    modport slave  (input  wrreq, data, rdreq,
                    output q, full, empty, almost_full, almost_empty, usedw, overflow, underflow);
`else
    modport master (output wrreq, data, rdreq,
                    input  q, full, empty, almost_full, almost_empty, usedw);
    modport slave  (input  wrreq, data, rdreq,
                    output q, full, empty, almost_full, almost_empty, usedw);
`endif
endinterface

// File: rtl/fifo_level.sv
// fifo_level: show-ahead flip-flop FIFO with occupancy count and level flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module fifo_level #(
    parameter int WIDTH         = 512,
    parameter int LOG_DEPTH     = 9,
    parameter int AFULL_THRESH  = (1 << LOG_DEPTH) - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input logic         clk,
    input logic         rst,
    fifo_level_if.slave bus
);
    localparam logic [LOG_DEPTH:0] DEPTH_W  = (LOG_DEPTH+1)'(1 << LOG_DEPTH);
    localparam logic [LOG_DEPTH:0] AFULL_W  = (LOG_DEPTH+1)'(AFULL_THRESH);
    localparam logic [LOG_DEPTH:0] AEMPTY_W = (LOG_DEPTH+1)'(AEMPTY_THRESH);

    logic [WIDTH-1:0]     mem_q [1 << LOG_DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   usedw_q, usedw_d;
    logic                 full, empty, wr_acc, rd_acc;

    assign full   = usedw_q == DEPTH_W;
    assign empty  = usedw_q == '0;
    assign wr_acc = bus.wrreq && !full && !rst;
    assign rd_acc = bus.rdreq && !empty && !rst;

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        usedw_d  = usedw_q + {{LOG_DEPTH{1'b0}}, wr_acc} - {{LOG_DEPTH{1'b0}}, rd_acc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
        end
    end

    // Storage is deliberately unreset; empty masks stale contents on q.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= bus.data;
    end

    assign bus.q            = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = usedw_q >= AFULL_W;
    assign bus.almost_empty = usedw_q <= AEMPTY_W;
    assign bus.usedw        = usedw_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (bus.wrreq && full);
            underflow_q <= underflow_q | (bus.rdreq && empty);
        end
    end
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed and random stimulus against a queue-based FIFO model.
module tb_fifo_level;
    localparam int W = 8, LD = 2, DEPTH = 4, AF = 3, AE = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0, bad = 0;

    logic [W-1:0] mq [$];
    logic         m_ovf = 1'b0, m_unf = 1'b0;

    fifo_level_if #(.WIDTH(W), .LOG_DEPTH(LD)) bus ();

    fifo_level #(.WIDTH(W), .LOG_DEPTH(LD), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n = mq.size();
        chk({tag, ".usedw"}, 32'(bus.usedw), 32'(n));
        chk({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
        chk({tag, ".afull"}, 32'(bus.almost_full), 32'(n >= AF));
        chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(n <= AE));
        chk({tag, ".q"}, 32'(bus.q), n > 0 ? 32'(mq[0]) : 32'h0);
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(bus.underflow), 32'(m_unf));
`endif
    endtask

    // One clock: apply inputs, advance the model on the edge, compare after it.
    task automatic step(input string tag, input logic r, input logic wr, input logic [W-1:0] d, input logic rd);
        bit was_full, was_empty;
        rst = r;
        bus.wrreq = wr;
        bus.data = d;
        bus.rdreq = rd;
        @(posedge clk);
        was_full = mq.size() == DEPTH;
        was_empty = mq.size() == 0;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && was_full) m_ovf = 1'b1;
            if (rd && was_empty) m_unf = 1'b1;
            if (rd && !was_empty) void'(mq.pop_front());
            if (wr && !was_full) mq.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.wrreq = 1'b0;
        bus.rdreq = 1'b0;
        bus.data = '0;
        step("rst0", 1, 0, 8'h00, 0);
        step("rst1", 1, 1, 8'hEE, 1);
        step("idle", 0, 0, 8'h00, 0);
        step("wr11", 0, 1, 8'h11, 0);
        step("wr22", 0, 1, 8'h22, 0);
        step("wr33", 0, 1, 8'h33, 0);
        step("wr44", 0, 1, 8'h44, 0);
        step("fullwr", 0, 1, 8'h99, 0);
        step("fullrw", 0, 1, 8'h55, 1);
        for (int i = 0; i < 3; i++) step("drain", 0, 0, 8'h00, 1);
        step("underrd", 0, 0, 8'h00, 1);
        step("emptyrw", 0, 1, 8'hA5, 1);
        step("rd1", 0, 0, 8'h00, 1);
        step("fill1", 0, 1, 8'hB0, 0);
        step("fill2", 0, 1, 8'hB1, 0);
        for (int i = 0; i < 6; i++) step("stream", 0, 1, 8'(8'hC0 + i), 1);
        step("fill3", 0, 1, 8'hD0, 0);
        step("midrst", 1, 1, 8'hDD, 0);
        step("wr77", 0, 1, 8'h77, 0);
        for (int ph = 0; ph < 4; ph++) begin
            int pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
            int pr = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
            for (int i = 0; i < 500; i++) begin
                logic r = ($urandom_range(99) < 2);
                logic wr = ($urandom_range(99) < pw);
                logic rd = ($urandom_range(99) < pr);
                step("rand", r, wr, 8'($urandom), rd);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_level.md
FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 WIDTH, 512, data word width in bits; SHALL be >= 1.
REQ-002 LOG_DEPTH, 9, log2 of slot count; depth = 2^LOG_DEPTH; SHALL be >= 1.
REQ-003 AFULL_THRESH, 2^LOG_DEPTH - 1, almost_full asserts when usedw >= this; SHALL be in 1..2^LOG_DEPTH.
REQ-004 AEMPTY_THRESH, 1, almost_empty asserts when usedw <= this; SHALL be in 0..2^LOG_DEPTH-1.
REQ-005 clock  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 wrreq  input  1  enqueue request.
REQ-008 data  input  WIDTH  write data, sampled on accepted write.
REQ-009 rdreq  input  1  dequeue request.
REQ-010 q  output  WIDTH  show-ahead head word.
REQ-011 full  output  1  usedw == 2^LOG_DEPTH.
REQ-012 empty  output  1  usedw == 0.
REQ-013 almost_full  output  1  usedw >= AFULL_THRESH.
REQ-014 almost_empty  output  1  usedw <= AEMPTY_THRESH.
REQ-015 usedw  output  LOG_DEPTH+1  current occupancy, 0..2^LOG_DEPTH.
REQ-016 overflow  output  1  sticky: write attempted while full (present only with FIFO_ERR_FLAGS_EN).
REQ-017 underflow  output  1  sticky: read attempted while empty (present only with FIFO_ERR_FLAGS_EN).

Function
REQ-018 Write accepted iff wrreq && !full in that cycle; read accepted iff rdreq && !empty; full/empty are current-cycle (registered-state) values.
REQ-019 Accepted write stores data at wr_ptr; wr_ptr increments by 1 next cycle, wrapping 2^LOG_DEPTH-1 -> 0.
REQ-020 Accepted read increments rd_ptr by 1 next cycle, same wrap rule; storage unchanged.
REQ-021 usedw next = usedw + accepted_write - accepted_read; both accepted -> unchanged.
REQ-022 Full with wrreq && rdreq: read accepted, write rejected, usedw decrements by 1.
REQ-023 Empty with wrreq && rdreq: write accepted, read rejected (no bypass), usedw becomes 1.
REQ-024 q SHALL be storage[rd_ptr] combinationally when !empty, and all-zero when empty; write-to-q latency 1 cycle after acceptance into an empty FIFO.
REQ-025 full, empty, almost_full, almost_empty SHALL be combinational decodes of registered usedw only, never of wrreq/rdreq.
REQ-026 Rejected requests SHALL change no pointer, counter or storage.
REQ-027 Storage SHALL be flip-flop array (no RAM macro), no reset on storage contents.

Reset
REQ-028 While reset is high at a posedge: usedw=0, rd_ptr=0, wr_ptr=0, overflow=0, underflow=0; wrreq/rdreq ignored that cycle.
REQ-029 Reset values: empty=1, full=0, almost_empty=1, almost_full=0 (given AFULL_THRESH>=1), q=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued words; first word written after reset appears on q one cycle after acceptance.

Configuration
REQ-031 Macro FIFO_ERR_FLAGS_EN defined: overflow sets on cycle after wrreq && full, underflow on cycle after rdreq && empty; both held until reset.
REQ-032 FIFO_ERR_FLAGS_EN undefined: overflow and underflow ports and logic absent; all other behaviour identical.

Verification (WIDTH=8, LOG_DEPTH=2, AFULL_THRESH=3, AEMPTY_THRESH=1)
REQ-033 Reset, then write 0x11,0x22,0x33,0x44 -> usedw 1,2,3,4; almost_full at usedw=3; full at 4; q=0x11 throughout.
REQ-034 From full, wrreq=1 data=0x55 plus rdreq=1 -> q becomes 0x22, usedw=3, 0x55 never read; with macro overflow=1.
REQ-035 From empty, wrreq=1 data=0xA5 and rdreq=1 same cycle -> next cycle usedw=1, q=0xA5, empty=0; with macro underflow=1.
REQ-036 Six write/read pairs streaming at usedw=2 -> pointers wrap, data out in order, usedw stays 2 every cycle.
REQ-037 usedw=3, assert reset one cycle -> usedw=0, empty=1, q=0, flags cleared; write 0x77 -> q=0x77 next cycle.
